// File: rtl/apb_reg_slave_if.sv
// APB signal bundle between one bridge psel line and a single completer.
interface apb_reg_slave_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] pr_data;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pr_data, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pr_data, pready, pslverr
   );
endinterface

// File: rtl/apb_reg_slave.sv
// APB completer holding an ID word, a write counter and scratch registers.
// Each transfer takes WAIT_CYCLES wait states; bad accesses complete with pslverr.
module apb_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA5B2_0001
) (
   input logic            hclk,
   input logic            hreset,
   apb_reg_slave_if.slave apb
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [31:0] REG_SPAN  = 32'(4 * NUM_REGS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        err_q, err_d;
   logic        write_q, write_d;
   logic [31:0] wr_count_q, wr_count_d;
   logic [31:0] regs_q [16];
   logic [31:0] regs_d [16];

   logic [31:0] offset;
   logic        dec_err;
   logic        commit;
   logic [31:0] rd_sel;

   // Registers 0 and 1 are read-only, so any write that lands on them is an error.
   always_comb begin
      offset  = apb.paddr - BASE_ADDR;
      dec_err = (apb.paddr < BASE_ADDR) ||
                (offset >= REG_SPAN) ||
                (apb.paddr[1:0] != 2'b00) ||
                (apb.pwrite && (offset[5:2] < 4'd2));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      write_d = write_q;
      case (state_q)
         S_IDLE: begin
            if (apb.psel && !apb.penable) begin
               idx_d   = offset[5:2];
               err_d   = dec_err;
               write_d = apb.pwrite;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!apb.psel) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A write lands on the edge that ends the response cycle; errored writes touch nothing.
   always_comb begin
      commit     = (state_q == S_RESP) && write_q && !err_q;
      wr_count_d = wr_count_q;
      for (int i = 0; i < 16; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (commit) begin
         regs_d[idx_q] = apb.pwdata;
         wr_count_d    = wr_count_q + 32'd1;
      end
   end

   always_comb begin
      case (idx_q)
         4'd0:    rd_sel = ID_VALUE;
         4'd1:    rd_sel = wr_count_q;
         default: rd_sel = regs_q[idx_q];
      endcase
      apb.pready  = (state_q == S_RESP);
      apb.pslverr = (state_q == S_RESP) && err_q;
      apb.pr_data = ((state_q == S_RESP) && !apb.pwrite && !err_q) ? rd_sel : 32'd0;
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         write_q    <= 1'b0;
         wr_count_q <= '0;
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         write_q    <= write_d;
         wr_count_q <= wr_count_d;
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end
endmodule
